// File: rtl/hazard_ctrl_pipe.sv
// EX/MEM/WB control pipeline with load-use stall, redirect flush and memory freeze.
// Carries an opaque control bundle and counts stall/flush events.
module hazard_ctrl_pipe #(
    parameter int CTRL_W = 16,
    parameter int RA_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic              id_reg_write,
    input  logic              id_mem_write,
    input  logic              id_mem_read,
    input  logic              id_branch,
    input  logic              id_jump,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [RA_W-1:0]   id_rd,
    input  logic [RA_W-1:0]   id_rs1,
    input  logic [RA_W-1:0]   id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_branch_taken,
    input  logic              mem_busy,
    output logic              ex_valid,
    output logic              mem_valid,
    output logic              wb_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_write,
    output logic              ex_mem_read,
    output logic              ex_branch,
    output logic              ex_jump,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [RA_W-1:0]   ex_rd,
    output logic              mem_reg_write,
    output logic              mem_mem_write,
    output logic              mem_mem_read,
    output logic [CTRL_W-1:0] mem_ctrl,
    output logic [RA_W-1:0]   mem_rd,
    output logic              wb_reg_write,
    output logic [CTRL_W-1:0] wb_ctrl,
    output logic [RA_W-1:0]   wb_rd,
    output logic              stall_if_id,
    output logic              flush_if_id,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
);

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_write;
        logic              mem_read;
        logic              branch;
        logic              jump;
        logic [CTRL_W-1:0] ctrl;
        logic [RA_W-1:0]   rd;
    } ex_t;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_write;
        logic              mem_read;
        logic [CTRL_W-1:0] ctrl;
        logic [RA_W-1:0]   rd;
    } mem_t;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic [CTRL_W-1:0] ctrl;
        logic [RA_W-1:0]   rd;
    } wb_t;

    ex_t  ex_q, ex_d;
    mem_t mem_q, mem_d;
    wb_t  wb_q, wb_d;

    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic redirect;
    logic stall_c;
    logic flush_c;

    assign load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) & id_valid &
                      ((id_use_rs1 & (id_rs1 == ex_q.rd)) |
                       (id_use_rs2 & (id_rs2 == ex_q.rd)));

    assign redirect = ex_q.valid & (ex_q.jump | (ex_q.branch & ex_branch_taken));

    always_comb begin
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        stall_c     = 1'b0;
        flush_c     = 1'b0;

        if (mem_busy) begin
            wb_d    = '0;
            stall_c = 1'b1;
        end else begin
            mem_d.valid     = ex_q.valid;
            mem_d.reg_write = ex_q.reg_write;
            mem_d.mem_write = ex_q.mem_write;
            mem_d.mem_read  = ex_q.mem_read;
            mem_d.ctrl      = ex_q.ctrl;
            mem_d.rd        = ex_q.rd;

            wb_d.valid     = mem_q.valid;
            wb_d.reg_write = mem_q.reg_write;
            wb_d.ctrl      = mem_q.ctrl;
            wb_d.rd        = mem_q.rd;

            if (redirect) begin
                flush_c = 1'b1;
                ex_d    = '0;
                if (flush_cnt_q != 16'hFFFF) begin
                    flush_cnt_d = flush_cnt_q + 16'd1;
                end
            end else if (load_use) begin
                stall_c = 1'b1;
                ex_d    = '0;
                if (stall_cnt_q != 16'hFFFF) begin
                    stall_cnt_d = stall_cnt_q + 16'd1;
                end
            end else if (id_valid) begin
                ex_d.valid     = 1'b1;
                ex_d.reg_write = id_reg_write;
                ex_d.mem_write = id_mem_write;
                ex_d.mem_read  = id_mem_read;
                ex_d.branch    = id_branch;
                ex_d.jump      = id_jump;
                ex_d.ctrl      = id_ctrl;
                ex_d.rd        = id_rd;
            end else begin
                ex_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Gate with rst_n so a held mem_busy cannot raise a stall during reset.
    assign stall_if_id = rst_n & stall_c;
    assign flush_if_id = rst_n & flush_c;

    assign ex_valid     = ex_q.valid;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_mem_write = ex_q.mem_write;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_branch    = ex_q.branch;
    assign ex_jump      = ex_q.jump;
    assign ex_ctrl      = ex_q.ctrl;
    assign ex_rd        = ex_q.rd;

    assign mem_valid     = mem_q.valid;
    assign mem_reg_write = mem_q.reg_write;
    assign mem_mem_write = mem_q.mem_write;
    assign mem_mem_read  = mem_q.mem_read;
    assign mem_ctrl      = mem_q.ctrl;
    assign mem_rd        = mem_q.rd;

    assign wb_valid     = wb_q.valid;
    assign wb_reg_write = wb_q.reg_write;
    assign wb_ctrl      = wb_q.ctrl;
    assign wb_rd        = wb_q.rd;

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Scoreboard bench for hazard_ctrl_pipe: retirements checked at WB,
// hazard controls and counters checked inline by the stimulus.
module tb_hazard_ctrl_pipe;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic        id_reg_write, id_mem_write, id_mem_read, id_branch, id_jump;
    logic [15:0] id_ctrl;
    logic [4:0]  id_rd, id_rs1, id_rs2;
    logic        id_use_rs1, id_use_rs2;
    logic        ex_branch_taken;
    logic        mem_busy;
    logic        ex_valid, mem_valid, wb_valid;
    logic        ex_reg_write, ex_mem_write, ex_mem_read, ex_branch, ex_jump;
    logic [15:0] ex_ctrl;
    logic [4:0]  ex_rd;
    logic        mem_reg_write, mem_mem_write, mem_mem_read;
    logic [15:0] mem_ctrl;
    logic [4:0]  mem_rd;
    logic        wb_reg_write;
    logic [15:0] wb_ctrl;
    logic [4:0]  wb_rd;
    logic        stall_if_id, flush_if_id;
    logic [15:0] stall_cnt, flush_cnt;

    typedef struct {
        logic [4:0]  rd;
        logic [15:0] ctrl;
        logic        rw;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   failures;

    hazard_ctrl_pipe #(.CTRL_W(16), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_reg_write(id_reg_write), .id_mem_write(id_mem_write),
        .id_mem_read(id_mem_read), .id_branch(id_branch), .id_jump(id_jump),
        .id_ctrl(id_ctrl), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
        .ex_mem_read(ex_mem_read), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_ctrl(ex_ctrl), .ex_rd(ex_rd),
        .mem_reg_write(mem_reg_write), .mem_mem_write(mem_mem_write),
        .mem_mem_read(mem_mem_read), .mem_ctrl(mem_ctrl), .mem_rd(mem_rd),
        .wb_reg_write(wb_reg_write), .wb_ctrl(wb_ctrl), .wb_rd(wb_rd),
        .stall_if_id(stall_if_id), .flush_if_id(flush_if_id),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && wb_valid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL wb_unexpected got rd=%0d ctrl=%h rw=%b expected none",
                         wb_rd, wb_ctrl, wb_reg_write);
            end else begin
                e = sb.pop_front();
                if (wb_rd !== e.rd || wb_ctrl !== e.ctrl || wb_reg_write !== e.rw) begin
                    failures++;
                    $display("FAIL wb_retire got rd=%0d ctrl=%h rw=%b expected rd=%0d ctrl=%h rw=%b",
                             wb_rd, wb_ctrl, wb_reg_write, e.rd, e.ctrl, e.rw);
                end
            end
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic push(input logic [4:0] rd, input logic [15:0] c, input logic rw);
        exp_t e;
        e.rd = rd;
        e.ctrl = c;
        e.rw = rw;
        sb.push_back(e);
    endtask

    task automatic id_idle();
        id_valid = 1'b0;
        id_reg_write = 1'b0;
        id_mem_write = 1'b0;
        id_mem_read = 1'b0;
        id_branch = 1'b0;
        id_jump = 1'b0;
        id_ctrl = 16'h0;
        id_rd = 5'd0;
        id_rs1 = 5'd0;
        id_rs2 = 5'd0;
        id_use_rs1 = 1'b0;
        id_use_rs2 = 1'b0;
    endtask

    task automatic id_set(input logic rw, input logic mw, input logic mr,
                          input logic br, input logic jp, input logic [15:0] c,
                          input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic u1, input logic u2);
        id_valid = 1'b1;
        id_reg_write = rw;
        id_mem_write = mw;
        id_mem_read = mr;
        id_branch = br;
        id_jump = jp;
        id_ctrl = c;
        id_rd = rd;
        id_rs1 = rs1;
        id_rs2 = rs2;
        id_use_rs1 = u1;
        id_use_rs2 = u2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        id_idle();
        repeat (4) tick();
    endtask

    task automatic lu_pair(input logic [4:0] ldrd, input logic [4:0] addrd,
                           input logic [15:0] ldc, input logic [15:0] addc,
                           input logic exp_stall);
        id_set(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ldc, ldrd, 5'd0, 5'd0, 1'b0, 1'b0);
        push(ldrd, ldc, 1'b1);
        tick();
        id_set(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, addc, addrd, ldrd, 5'd3, 1'b1, 1'b0);
        push(addrd, addc, 1'b1);
        #1;
        chk("lu_stall", 32'(stall_if_id), 32'(exp_stall));
        chk("lu_flush", 32'(flush_if_id), 0);
        tick();
        if (exp_stall) begin
            chk("lu_ex_bubble", 32'(ex_valid), 0);
            chk("lu_stall_clear", 32'(stall_if_id), 0);
            tick();
        end
        chk("lu_ex_valid", 32'(ex_valid), 1);
        chk("lu_ex_rd", 32'(ex_rd), 32'(addrd));
        id_idle();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        mem_busy = 1'b0;
        ex_branch_taken = 1'b0;
        id_idle();
        #2;
        mem_busy = 1'b1;
        #1;
        chk("rst_ex_valid", 32'(ex_valid), 0);
        chk("rst_mem_valid", 32'(mem_valid), 0);
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_stall", 32'(stall_if_id), 0);
        chk("rst_flush", 32'(flush_if_id), 0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        chk("rst_flush_cnt", 32'(flush_cnt), 0);
        mem_busy = 1'b0;
        #9;
        rst_n = 1'b1;

        // straight-line ADD rd=5, first edge after release captures
        id_set(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0011, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1);
        push(5'd5, 16'h0011, 1'b1);
        #1;
        chk("sl_stall0", 32'(stall_if_id), 0);
        chk("sl_flush0", 32'(flush_if_id), 0);
        tick();
        id_idle();
        chk("sl_ex_valid", 32'(ex_valid), 1);
        chk("sl_ex_rd", 32'(ex_rd), 5);
        tick();
        chk("sl_mem_rd", 32'(mem_rd), 5);
        chk("sl_wb_early", 32'(wb_valid), 0);
        tick();
        chk("sl_wb_valid", 32'(wb_valid), 1);
        chk("sl_wb_rd", 32'(wb_rd), 5);
        chk("sl_wb_rw", 32'(wb_reg_write), 1);
        chk("sl_cnts", 32'({stall_cnt, flush_cnt}), 0);
        drain();

        // load-use, then same with rd=0
        lu_pair(5'd7, 5'd8, 16'h0222, 16'h0333, 1'b1);
        chk("lu_stall_cnt", 32'(stall_cnt), 1);
        drain();
        lu_pair(5'd0, 5'd8, 16'h0444, 16'h0445, 1'b0);
        chk("lu0_stall_cnt", 32'(stall_cnt), 1);
        drain();

        // taken branch overrides simultaneous load-use
        id_set(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0666, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0);
        push(5'd9, 16'h0666, 1'b0);
        tick();
        id_set(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0777, 5'd12, 5'd9, 5'd0, 1'b1, 1'b0);
        ex_branch_taken = 1'b1;
        #1;
        chk("br_flush", 32'(flush_if_id), 1);
        chk("br_stall", 32'(stall_if_id), 0);
        tick();
        ex_branch_taken = 1'b0;
        id_idle();
        chk("br_ex_bubble", 32'(ex_valid), 0);
        chk("br_flush_cnt", 32'(flush_cnt), 1);
        chk("br_stall_cnt", 32'(stall_cnt), 1);
        drain();

        // not-taken branch
        id_set(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0888, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1);
        push(5'd0, 16'h0888, 1'b0);
        tick();
        id_set(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0999, 5'd10, 5'd1, 5'd0, 1'b1, 1'b0);
        push(5'd10, 16'h0999, 1'b1);
        #1;
        chk("nt_flush", 32'(flush_if_id), 0);
        chk("nt_stall", 32'(stall_if_id), 0);
        tick();
        id_idle();
        chk("nt_ex_rd", 32'(ex_rd), 10);
        chk("nt_flush_cnt", 32'(flush_cnt), 1);
        drain();

        // freeze with JAL in EX, ADDI in MEM
        id_set(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0aaa, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0);
        push(5'd2, 16'h0aaa, 1'b1);
        tick();
        id_set(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0bbb, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
        push(5'd1, 16'h0bbb, 1'b1);
        tick();
        id_set(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0ccc, 5'd11, 5'd0, 5'd0, 1'b0, 1'b0);
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fz_stall", 32'(stall_if_id), 1);
            chk("fz_flush", 32'(flush_if_id), 0);
            tick();
            chk("fz_ex", 32'({ex_jump, ex_ctrl, ex_rd}), 32'({1'b1, 16'h0bbb, 5'd1}));
            chk("fz_mem", 32'({mem_ctrl, mem_rd}), 32'({16'h0aaa, 5'd2}));
            chk("fz_wb_valid", 32'(wb_valid), 0);
            chk("fz_flush_cnt", 32'(flush_cnt), 1);
        end
        mem_busy = 1'b0;
        #1;
        chk("rel_flush", 32'(flush_if_id), 1);
        chk("rel_stall", 32'(stall_if_id), 0);
        tick();
        id_idle();
        chk("rel_ex_bubble", 32'(ex_valid), 0);
        chk("rel_flush_cnt", 32'(flush_cnt), 2);
        drain();

        // saturation: preload near the top, then real load-use events
        force dut.stall_cnt_q = 16'hFFFD;
        tick();
        release dut.stall_cnt_q;
        lu_pair(5'd7, 5'd8, 16'h1001, 16'h1002, 1'b1);
        chk("sat_fffe", 32'(stall_cnt), 32'h0000FFFE);
        lu_pair(5'd7, 5'd8, 16'h1003, 16'h1004, 1'b1);
        chk("sat_ffff", 32'(stall_cnt), 32'h0000FFFF);
        lu_pair(5'd7, 5'd8, 16'h1005, 16'h1006, 1'b1);
        chk("sat_hold", 32'(stall_cnt), 32'h0000FFFF);
        drain();

        // async reset mid-stall and mid-freeze
        id_set(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h2001, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        id_set(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h2002, 5'd8, 5'd7, 5'd0, 1'b1, 1'b0);
        #1;
        chk("pre_rst_stall", 32'(stall_if_id), 1);
        mem_busy = 1'b1;
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("arst_valids", 32'({ex_valid, mem_valid, wb_valid}), 0);
        chk("arst_ex", 32'({ex_mem_read, ex_reg_write, ex_ctrl, ex_rd}), 0);
        chk("arst_hz", 32'({stall_if_id, flush_if_id}), 0);
        chk("arst_stall_cnt", 32'(stall_cnt), 0);
        chk("arst_flush_cnt", 32'(flush_cnt), 0);
        mem_busy = 1'b0;
        id_idle();
        #2;
        rst_n = 1'b1;
        id_set(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0ddd, 5'd13, 5'd0, 5'd0, 1'b0, 1'b0);
        push(5'd13, 16'h0ddd, 1'b1);
        tick();
        id_idle();
        chk("post_rst_ex_rd", 32'({ex_valid, ex_rd}), 32'({1'b1, 5'd13}));
        drain();

        chk("sb_empty", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
